// File: rtl/logic_op_fifo.sv
// Operation-staging FIFO in front of the 32-bit logic unit: first-word-fall-through,
// zero-forced head when empty, sticky overflow on pushes attempted while full.
module logic_op_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [2:0]               out_sel,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // A push attempt against a full FIFO is recorded even during flush.
      if (in_valid && full) overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // Storage carries no reset; stale contents are hidden by the empty-forcing below.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{sel: in_sel, a: in_a, b: in_b};
  end

  assign head    = mem[rd_ptr];
  assign out_a   = empty ? '0 : head.a;
  assign out_b   = empty ? '0 : head.b;
  assign out_sel = empty ? 3'b000 : head.sel;
endmodule

// File: tb/tb_logic_op_fifo.sv
// Self-checking bench for logic_op_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_logic_op_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic [2:0]        in_sel = '0;
  logic              in_ready, out_valid, overflow;
  logic [WIDTH-1:0]  out_a, out_b;
  logic [2:0]        out_sel;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  op_t q[$];
  bit  movf = 1'b0;

  logic_op_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_sel(out_sel),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    chk("in_ready", in_ready, 64'(n < DEPTH));
    chk("out_valid", out_valid, 64'(n > 0));
    chk("count", count, 64'(n));
    chk("overflow", overflow, 64'(movf));
    chk("out_sel", out_sel, (n > 0) ? 64'(q[0].sel) : 64'd0);
    chk("out_a", out_a, (n > 0) ? 64'(q[0].a) : 64'd0);
    chk("out_b", out_b, (n > 0) ? 64'(q[0].b) : 64'd0);
  endtask

  // Compare the current state, advance the model by one edge, then clock the DUT.
  task automatic tick();
    bit  do_push, do_pop;
    op_t op;
    check_state();
    op = '{sel: in_sel, a: in_a, b: in_b};
    if (in_valid && q.size() == DEPTH) movf = 1'b1;
    if (flush) begin
      q.delete();
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(op);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic rdy);
    in_valid  = v;
    in_sel    = s;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);

    // Fill to full with no consumer
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i), 32'h0000FFFF, 32'h0, 1'b0);
      tick();
      chk("fill_count", count, 64'(i + 1));
      chk("fill_head", out_sel, 0);
    end
    chk("full_ready", in_ready, 0);

    // Push while full is dropped and flagged
    drive(1'b1, 3'b111, 32'hDEADBEEF, 32'h0, 1'b0);
    tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    drive(1'b0, 3'b000, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_sel", out_sel, 64'(i));
      tick();
    end
    chk("drained", out_valid, 0);
    chk("ovf_hold", overflow, 1);

    // Continuous streaming, pointers wrap twice
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), $urandom, $urandom, 1'b1);
      tick();
      chk("stream_count", count, 1);
      chk("stream_sel", out_sel, 64'(i));
    end
    drive(1'b0, 3'b000, '0, '0, 1'b1);
    tick();
    chk("stream_empty", out_valid, 0);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i + 1), $urandom, $urandom, 1'b0);
      tick();
    end
    drive(1'b1, 3'b110, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ovf", overflow, 1);
    tick();

    // Asynchronous reset between edges
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'(i + 2), $urandom, $urandom, 1'b0);
      tick();
    end
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_ovf", overflow, 0);
    chk("arst_sel", out_sel, 0);
    chk("arst_a", out_a, 0);
    q.delete();
    movf = 1'b0;
    #1;
    reset = 1'b0;
    drive(1'b1, 3'b101, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0);
    tick();
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    chk("post_sel", out_sel, 3'b101);
    chk("post_a", out_a, 32'hF0F0F0F0);
    chk("post_b", out_b, 32'h0F0F0F0F);
    chk("post_count", count, 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 3'b000, '0, '0, 1'b1);
    repeat (DEPTH + 1) tick();
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
